xif_copro_ex_multi: RTL

Next-generation execution stage for the XIF coprocessor. It accepts one decoded instruction per cycle (operands, operator, tag) and executes it in a single execution slot. Single-cycle and multi-cycle operations have op-dependent latency. Completed results go into a parametrised in-order result FIFO, so the execution slot keeps working while the writeback side stalls. It sits between the coprocessor decode/issue logic and the XIF result interface.

---
 rtl/xif_copro_ex_multi.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/xif_copro_ex_multi.sv
// xif_copro_ex_multi: XIF coprocessor execution stage.
// Purpose: accepts one decoded instruction per cycle into a single execution
//   slot, runs it with op-dependent latency (1 cycle, or MC_LATENCY cycles for
//   POPCNT/CLZ) and pushes completed result+tag into an in-order result FIFO.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   flush_i              synchronous kill of slot and FIFO contents
//   operand_a_i/_b_i     source operands (b supplies the rotate amount)
//   operator_i, tag_i    operation and instruction tag
//   in_valid_i/in_ready_o    issue handshake
//   out_valid_o/out_ready_i  result handshake
//   tag_o, result_o      FIFO head (0 when empty)
//   count_o              FIFO occupancy

package xif_copro_ex_multi_pkg;
  typedef enum logic [2:0] {
    NONE     = 3'd0,
    BITREV   = 3'd1,
    ROTLEFT  = 3'd2,
    ROTRIGHT = 3'd3,
    POPCNT   = 3'd4,
    CLZ      = 3'd5
  } copro_op_e;
endpackage

module xif_copro_ex_multi
  import xif_copro_ex_multi_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter type         tag_t      = logic,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MC_LATENCY = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic [XLEN-1:0]              operand_a_i,
  input  logic [XLEN-1:0]              operand_b_i,
  input  copro_op_e                    operator_i,
  input  tag_t                         tag_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output tag_t                         tag_o,
  output logic [XLEN-1:0]              result_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned SHW   = $clog2(XLEN);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LAT_W = 4;

  // Execution slot
  logic              r_busy;
  logic [LAT_W-1:0]  r_cnt;
  copro_op_e         r_op;
  logic [XLEN-1:0]   r_a;
  logic [SHW-1:0]    r_amt;
  tag_t              r_tag;

  // Result FIFO
  logic [XLEN-1:0]   r_res_mem [DEPTH];
  tag_t              r_tag_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_full;
  logic              w_complete;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_is_mc;
  logic [XLEN-1:0]   w_result;
  logic [XLEN-1:0]   w_bitrev;
  logic [XLEN-1:0]   w_popcnt;
  logic [XLEN-1:0]   w_clz;
  logic [XLEN-1:0]   w_rotl;
  logic [XLEN-1:0]   w_rotr;
  logic [SHW:0]      w_inv_amt;
  logic              w_unused_b;

  // Only the low SHW bits of operand B carry the rotate amount.
  assign w_unused_b = ^operand_b_i[XLEN-1:SHW];

  // Handshake and completion control; push is blocked on a full FIFO even if a
  // pop happens in the same cycle.
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_complete  = r_busy & (r_cnt == '0) & ~w_full;
  assign in_ready_o  = ~flush_i & (~r_busy | w_complete);
  assign w_accept    = in_valid_i & in_ready_o;
  assign w_push      = w_complete & ~flush_i;
  assign out_valid_o = (r_count != '0);
  assign w_pop       = out_valid_o & out_ready_i & ~flush_i;
  assign w_is_mc     = (operator_i == POPCNT) | (operator_i == CLZ);

  // FIFO head is read straight from registered storage, gated to 0 when empty.
  assign result_o = out_valid_o ? r_res_mem[r_rptr] : '0;
  assign tag_o    = out_valid_o ? r_tag_mem[r_rptr] : tag_t'(0);
  assign count_o  = r_count;

  // Rotates: a shift by XLEN yields 0, so amount 0 falls out as a unchanged.
  assign w_inv_amt = (SHW+1)'(XLEN) - (SHW+1)'(r_amt);
  assign w_rotl    = (r_a << r_amt) | (r_a >> w_inv_amt);
  assign w_rotr    = (r_a >> r_amt) | (r_a << w_inv_amt);

  // Result computation from the slot contents.
  always_comb begin
    w_bitrev = '0;
    w_popcnt = '0;
    w_clz    = XLEN'(XLEN);
    w_result = '0;
    for (int i = 0; i < XLEN; i++) begin
      w_bitrev[i] = r_a[XLEN-1-i];
      w_popcnt    = w_popcnt + XLEN'(r_a[i]);
      // Highest set bit wins because it is visited last.
      if (r_a[i]) w_clz = XLEN'(XLEN - 1 - i);
    end
    case (r_op)
      BITREV:   w_result = w_bitrev;
      ROTLEFT:  w_result = w_rotl;
      ROTRIGHT: w_result = w_rotr;
      POPCNT:   w_result = w_popcnt;
      CLZ:      w_result = w_clz;
      default:  w_result = '0;
    endcase
  end

  // Execution slot: load on accept, count down, free on completion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_op   <= NONE;
      r_a    <= '0;
      r_amt  <= '0;
      r_tag  <= tag_t'(0);
    end else if (flush_i) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_busy <= 1'b1;
      r_cnt  <= w_is_mc ? LAT_W'(MC_LATENCY - 1) : '0;
      r_op   <= operator_i;
      r_a    <= operand_a_i;
      r_amt  <= operand_b_i[SHW-1:0];
      r_tag  <= tag_i;
    end else if (w_complete) begin
      r_busy <= 1'b0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - LAT_W'(1);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // FIFO storage; contents are only observable through the occupancy gate.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_res_mem[r_wptr] <= w_result;
      r_tag_mem[r_wptr] <= r_tag;
    end
  end

endmodule
